// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-port arbiter and sequencer
// for the shared 16-bit combinational ALU.
module alu_arbiter #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_last;
  logic                r_owner;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [OP_W-1:0]     r_op;
  logic [DATA_W-1:0]   r_result;
  logic                r_zero;

  logic                w_idle;
  logic                w_gnt_vld;
  logic                w_gnt_id;
  logic                w_rsp_rdy;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [OP_W-1:0]     w_op;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    w_gnt_vld = req0_valid | req1_valid;
    w_gnt_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt_id = ~r_last;
    end else if (req1_valid) begin
      w_gnt_id = 1'b1;
    end
  end

  assign w_idle    = (r_state == IDLE) & ~reset;
  assign w_a       = w_gnt_id ? req1_a  : req0_a;
  assign w_b       = w_gnt_id ? req1_b  : req0_b;
  assign w_op      = w_gnt_id ? req1_op : req0_op;
  assign w_rsp_rdy = r_owner ? rsp1_ready : rsp0_ready;

  assign req0_ready = w_idle & w_gnt_vld & ~w_gnt_id;
  assign req1_ready = w_idle & w_gnt_vld &  w_gnt_id;

  assign rsp0_valid = r_rsp_valid & ~r_owner & ~reset;
  assign rsp1_valid = r_rsp_valid &  r_owner & ~reset;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;

  assign alu_a  = r_a;
  assign alu_b  = r_b;
  assign alu_op = r_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_a     <= w_a;
            r_b     <= w_b;
            r_op    <= w_op;
            r_owner <= w_gnt_id;
            r_last  <= w_gnt_id;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_result    <= alu_result;
          r_zero      <= alu_zero;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (w_rsp_rdy) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: random and directed stimulus against a
// transaction-level model of the ALU arbiter.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  p;
  logic [1:0]  rr;
  logic [15:0] ra [2];
  logic [15:0] rb [2];
  logic [2:0]  rop [2];

  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp_result;
  logic        rsp_zero;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_zero;

  int n_chk;
  int n_fail;

  bit          m_busy;
  bit          m_resp;
  int          m_last;
  int          m_owner;
  logic [15:0] m_res;
  logic        m_z;
  logic [15:0] m_alu_a;
  logic [15:0] m_alu_b;
  logic [2:0]  m_alu_op;
  int          last_acc;
  int          acc_q[$];

  alu_arbiter dut (
    .clk        (clk),
    .reset      (rst),
    .req0_valid (p[0]),
    .req0_ready (req0_ready),
    .req0_a     (ra[0]),
    .req0_b     (rb[0]),
    .req0_op    (rop[0]),
    .req1_valid (p[1]),
    .req1_ready (req1_ready),
    .req1_a     (ra[1]),
    .req1_b     (rb[1]),
    .req1_op    (rop[1]),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rr[0]),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rr[1]),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_alu(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [2:0]  op
  );
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      3'd5:    return {b[7:0], 8'h00};
      default: return 16'd0;
    endcase
  endfunction

  always_comb begin
    alu_result = ref_alu(alu_a, alu_b, alu_op);
    alu_zero   = (alu_result == 16'd0);
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(
    input int          id,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [2:0]  op
  );
    p[id]   = 1'b1;
    ra[id]  = a;
    rb[id]  = b;
    rop[id] = op;
  endtask

  task automatic step();
    int w;
    #1;
    w = -1;
    if (!rst && !m_busy) begin
      if (p[0] && p[1]) w = (m_last == 0) ? 1 : 0;
      else if (p[0])    w = 0;
      else if (p[1])    w = 1;
    end
    chk("req0_ready", req0_ready, w == 0);
    chk("req1_ready", req1_ready, w == 1);
    if (rst) begin
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
    end
    last_acc = -1;
    if (rst) begin
      m_busy = 0; m_resp = 0; m_last = 1; m_owner = 0;
      m_res = 0; m_z = 0;
      m_alu_a = 0; m_alu_b = 0; m_alu_op = 0;
    end else if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_last = w;
        m_alu_a = ra[w]; m_alu_b = rb[w]; m_alu_op = rop[w];
        last_acc = w;
      end
    end else if (!m_resp) begin
      m_resp = 1;
      m_res  = ref_alu(m_alu_a, m_alu_b, m_alu_op);
      m_z    = (m_res == 16'd0);
    end else if (rr[m_owner]) begin
      m_busy = 0; m_resp = 0;
    end
    @(posedge clk);
    #1;
    if (last_acc >= 0) begin
      p[last_acc] = 1'b0;
      acc_q.push_back(last_acc);
    end
    chk("rsp0_valid", rsp0_valid, m_resp && m_owner == 0);
    chk("rsp1_valid", rsp1_valid, m_resp && m_owner == 1);
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_zero", rsp_zero, m_z);
    chk("alu_a", alu_a, m_alu_a);
    chk("alu_b", alu_b, m_alu_b);
    chk("alu_op", alu_op, m_alu_op);
  endtask

  task automatic wait_rsp(input int id, output int n);
    bit seen;
    seen = 0;
    n = 0;
    while (!seen && n < 20) begin
      step();
      n++;
      seen = (id == 0) ? rsp0_valid : rsp1_valid;
    end
    if (!seen) chk("rsp_timeout", 0, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    p = 2'b00;
    rr = 2'b11;
    while (m_busy && k < 20) begin
      step();
      k++;
    end
    if (m_busy) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int k;
    n_chk = 0;
    n_fail = 0;
    m_busy = 0; m_resp = 0; m_last = 1; m_owner = 0;
    m_res = 0; m_z = 0;
    m_alu_a = 0; m_alu_b = 0; m_alu_op = 0;
    p = 2'b00;
    rr = 2'b11;
    for (int i = 0; i < 2; i++) begin
      ra[i] = 0; rb[i] = 0; rop[i] = 0;
    end

    // Tie from reset: requester 0 first.
    rst = 1'b1;
    issue(0, 16'h0005, 16'h0005, 3'd1);
    issue(1, 16'h00F0, 16'h000F, 3'd3);
    step();
    step();
    rst = 1'b0;
    wait_rsp(0, n);
    chk("tie_res0", rsp_result, 16'h0000);
    chk("tie_zero0", rsp_zero, 1);
    wait_rsp(1, n);
    chk("tie_res1", rsp_result, 16'h00FF);
    chk("tie_zero1", rsp_zero, 0);
    drain();
    chk("tie_order0", acc_q[0], 0);
    chk("tie_order1", acc_q[1], 1);

    // Both continuously valid: strict alternation.
    acc_q.delete();
    k = 0;
    while (acc_q.size() < 6 && k < 60) begin
      for (int i = 0; i < 2; i++)
        if (!p[i]) issue(i, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
      step();
      k++;
    end
    chk("fair_count", acc_q.size(), 6);
    for (int i = 0; i < acc_q.size(); i++)
      chk("fair_order", acc_q[i], i % 2);
    drain();

    // Add with latency check.
    issue(0, 16'h0003, 16'h0004, 3'd0);
    wait_rsp(0, n);
    chk("add_latency", n, 2);
    chk("add_res", rsp_result, 16'h0007);
    chk("add_zero", rsp_zero, 0);
    drain();

    // SLT under backpressure with req0 pending.
    rr = 2'b00;
    issue(1, 16'hFFFF, 16'h0001, 3'd4);
    wait_rsp(1, n);
    issue(0, 16'h1111, 16'h2222, 3'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("slt_hold_v", rsp1_valid, 1);
      chk("slt_hold_r", rsp_result, 16'h0001);
      chk("slt_pend", p[0], 1);
    end
    rr = 2'b10;
    step();
    rr = 2'b11;
    acc_q.delete();
    step();
    chk("slt_next_acc", acc_q.size(), 1);
    drain();

    // LUI and unsupported opcode.
    issue(0, 16'h5555, 16'h12AB, 3'd5);
    wait_rsp(0, n);
    chk("lui_res", rsp_result, 16'hAB00);
    drain();
    issue(0, 16'h1234, 16'h0042, 3'd7);
    wait_rsp(0, n);
    chk("op7_res", rsp_result, 16'h0000);
    chk("op7_zero", rsp_zero, 1);
    drain();

    // Reset during response.
    rr = 2'b00;
    issue(0, 16'h0101, 16'h0202, 3'd0);
    wait_rsp(0, n);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_v0", rsp0_valid, 0);
    chk("mrst_a", alu_a, 0);
    chk("mrst_b", alu_b, 0);
    rr = 2'b11;
    acc_q.delete();
    issue(0, 16'h0001, 16'h0001, 3'd0);
    issue(1, 16'h0002, 16'h0002, 3'd0);
    step();
    chk("mrst_tie", (acc_q.size() == 1) ? acc_q[0] : -1, 0);
    drain();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            ra[i] = 16'($urandom);
            rb[i] = ($urandom_range(0, 3) == 0) ? ra[i] : 16'($urandom);
            rop[i] = 3'($urandom_range(0, 7));
            p[i] = 1'b1;
          end
        end else if ($urandom_range(0, 9) == 0) begin
          p[i] = 1'b0;
        end
        rr[i] = 1'($urandom_range(0, 1));
      end
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
